// File: rtl/operand_fetch_mux.sv
// operand_fetch_mux
//   Operand fetch unit for the CPU core. It either selects one of NUM_SRC
//   register sources from a flattened bus, or performs a memory read.
//   Memory reads use a level req / ack handshake with a bounded wait.
//   The operand is registered and marked with a one-enabled-period valid
//   strobe. The bad_sel and timeout_err strobes qualify that completion.
//
//   All state advances only on clock edges where clk_en=1.
//   reset_n is asynchronous and active low.
//
//   Optional build macro: OPERAND_FETCH_WB_FWD_EN
//     When this macro is defined, a register fetch whose source index
//     matches an in-flight writeback (wb_en, wb_sel) returns wb_data
//     instead of the stale bus value. Memory fetches are not affected.
//     When it is not defined, the writeback ports are present but unused.

module operand_fetch_mux #(
    parameter int DATA_W       = 4,
    parameter int ADDR_W       = 12,
    parameter int NUM_SRC      = 24,
    parameter int SEL_W        = 5,
    parameter int MEM_WAIT_MAX = 7
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clk_en,
    input  logic                      fetch_req,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      is_mem,
    input  logic [ADDR_W-1:0]         addr_in,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      wb_en,
    input  logic [SEL_W-1:0]          wb_sel,
    input  logic [DATA_W-1:0]         wb_data,
    output logic [DATA_W-1:0]         out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      bad_sel,
    output logic                      timeout_err
);

    // The wait counter only has to reach MEM_WAIT_MAX-1, so it never wraps.
    localparam int CNT_W     = $clog2(MEM_WAIT_MAX + 1);
    localparam int SRC_SLOTS = 2 ** SEL_W;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_WAIT_MAX - 1);
    localparam logic [SEL_W:0]   NUM_SRC_L = (SEL_W + 1)'(NUM_SRC);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                bad_sel_q, bad_sel_d;
    logic                timeout_err_q, timeout_err_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    // The flattened bus is unpacked into an array that covers every selector
    // code. Codes at or above NUM_SRC are padded with zero, so the indexed
    // read is always in range. The range check below decides whether such a
    // value is ever used.
    logic [DATA_W-1:0]   src_arr [SRC_SLOTS];

    for (genvar gi = 0; gi < SRC_SLOTS; gi++) begin : g_src
        if (gi < NUM_SRC) begin : g_used
            assign src_arr[gi] = src_bus[gi*DATA_W +: DATA_W];
        end else begin : g_pad
            assign src_arr[gi] = '0;
        end
    end

    logic                sel_in_range;
    logic [DATA_W-1:0]   reg_operand;

    assign sel_in_range = ({1'b0, sel} < NUM_SRC_L);

`ifdef OPERAND_FETCH_WB_FWD_EN
    // A writeback to the same register in this cycle is newer than the bus.
    logic fwd_hit;
    assign fwd_hit     = wb_en && (wb_sel == sel);
    assign reg_operand = fwd_hit ? wb_data : src_arr[sel];
`else
    // The writeback ports stay on the interface but carry no meaning in this build.
    logic unused_wb;
    assign unused_wb   = ^{wb_en, wb_sel, wb_data};
    assign reg_operand = src_arr[sel];
`endif

    // Next-state and output decode. Strobes default low and pulse for one enabled period.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        out_valid_d   = 1'b0;
        bad_sel_d     = 1'b0;
        timeout_err_d = 1'b0;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;

        case (state_q)
            ST_IDLE: begin
                // mem_ack is deliberately not looked at here.
                if (fetch_req) begin
                    if (is_mem) begin
                        mem_addr_d = addr_in;
                        mem_req_d  = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_MEM_WAIT;
                    end else begin
                        out_valid_d = 1'b1;
                        if (sel_in_range) begin
                            out_d = reg_operand;
                        end else begin
                            bad_sel_d = 1'b1;
                        end
                    end
                end
            end

            ST_MEM_WAIT: begin
                // An ack that arrives in the final wait cycle still wins over the timeout.
                if (mem_ack) begin
                    out_d       = mem_rdata;
                    out_valid_d = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    out_valid_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State register. An async reset drops mem_req immediately. Otherwise
    // state advances only on enabled edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            bad_sel_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else if (clk_en) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            bad_sel_q     <= bad_sel_d;
            timeout_err_q <= timeout_err_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign bad_sel     = bad_sel_q;
    assign timeout_err = timeout_err_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_operand_fetch_mux.sv
// Testbench for operand_fetch_mux: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_operand_fetch_mux;

    localparam int DATA_W       = 4;
    localparam int ADDR_W       = 12;
    localparam int NUM_SRC      = 24;
    localparam int SEL_W        = 5;
    localparam int MEM_WAIT_MAX = 7;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b1;
    logic                      clk_en = 1'b0;
    logic                      fetch_req = 1'b0;
    logic [SEL_W-1:0]          sel = '0;
    logic                      is_mem = 1'b0;
    logic [ADDR_W-1:0]         addr_in = '0;
    logic [NUM_SRC*DATA_W-1:0] src_bus;
    logic                      mem_req_w;
    logic [ADDR_W-1:0]         mem_addr_w;
    logic                      mem_ack = 1'b0;
    logic [DATA_W-1:0]         mem_rdata = '0;
    logic                      wb_en = 1'b0;
    logic [SEL_W-1:0]          wb_sel = '0;
    logic [DATA_W-1:0]         wb_data = '0;
    logic [DATA_W-1:0]         out_w;
    logic                      out_valid_w, busy_w, bad_sel_w, timeout_err_w;

    logic [DATA_W-1:0] src_arr [NUM_SRC];

    always_comb begin
        src_bus = '0;
        for (int k = 0; k < NUM_SRC; k++) src_bus[k*DATA_W +: DATA_W] = src_arr[k];
    end

    operand_fetch_mux #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC),
        .SEL_W(SEL_W), .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .fetch_req(fetch_req),
        .sel(sel), .is_mem(is_mem), .addr_in(addr_in), .src_bus(src_bus),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .out(out_w), .out_valid(out_valid_w), .busy(busy_w),
        .bad_sel(bad_sel_w), .timeout_err(timeout_err_w)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: one outstanding fetch, counted in enabled wait cycles.
    bit                m_busy;
    int                m_waited;
    logic [DATA_W-1:0] m_out;
    bit                m_valid, m_bad, m_to, m_req;
    logic [ADDR_W-1:0] m_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_out = '0; m_valid = 0; m_bad = 0; m_to = 0;
        m_req = 0; m_addr = '0;
    endtask

    // One enabled edge of the reference behaviour, using the inputs as driven.
    task automatic model_step();
        m_valid = 0; m_bad = 0; m_to = 0;
        if (!m_busy) begin
            if (fetch_req) begin
                if (is_mem) begin
                    m_busy = 1; m_waited = 0; m_req = 1; m_addr = addr_in;
                end else begin
                    m_valid = 1;
                    if (int'(sel) < NUM_SRC) begin
`ifdef OPERAND_FETCH_WB_FWD_EN
                        if (wb_en && wb_sel == sel) m_out = wb_data;
                        else m_out = src_arr[int'(sel)];
`else
                        m_out = src_arr[int'(sel)];
`endif
                    end else begin
                        m_bad = 1;
                    end
                end
            end
        end else begin
            if (mem_ack) begin
                m_out = mem_rdata; m_valid = 1; m_req = 0; m_busy = 0;
            end else begin
                m_waited++;
                if (m_waited == MEM_WAIT_MAX) begin
                    m_valid = 1; m_to = 1; m_req = 0; m_busy = 0;
                end
            end
        end
    endtask

    // Advance one clock and settle 1 ns past the edge.
    task automatic step(input bit en);
        clk_en = en;
        @(posedge clk);
        if (reset_n && clk_en) model_step();
        #1;
    endtask

    task automatic reset_pulse();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_mem_req", 32'(mem_req_w), 32'd0);
        step(1);
        reset_n = 1'b1;
    endtask

    // The DUT is compared against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out",         32'(out_w),         32'(m_out));
            check("out_valid",   32'(out_valid_w),   32'(m_valid));
            check("bad_sel",     32'(bad_sel_w),     32'(m_bad));
            check("timeout_err", 32'(timeout_err_w), 32'(m_to));
            check("mem_req",     32'(mem_req_w),     32'(m_req));
            check("mem_addr",    32'(mem_addr_w),    32'(m_addr));
            check("busy",        32'(busy_w),        32'(m_busy));
        end
    end

    initial begin
        int n;
        for (int k = 0; k < NUM_SRC; k++) src_arr[k] = DATA_W'(k & 15);

        // Reset state
        #1 reset_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        check("reset_out", 32'(out_w), 32'd0);
        check("reset_valid", 32'(out_valid_w), 32'd0);
        check("reset_mem_req", 32'(mem_req_w), 32'd0);
        step(1); step(1);
        reset_n = 1'b1;
        step(1);

        // Register fetch of source 5
        sel = 5'd5; is_mem = 0; fetch_req = 1;
        step(1);
        fetch_req = 0;
        check("t1_out", 32'(out_w), 32'h5);
        check("t1_valid", 32'(out_valid_w), 32'd1);
        check("t1_busy", 32'(busy_w), 32'd0);
        step(1);
        check("t1_valid_drop", 32'(out_valid_w), 32'd0);

        // Memory fetch, ack on the third enabled cycle
        addr_in = 12'hA3C; is_mem = 1; fetch_req = 1;
        step(1);
        fetch_req = 0;
        check("t2_req", 32'(mem_req_w), 32'd1);
        check("t2_addr", 32'(mem_addr_w), 32'hA3C);
        step(1);
        check("t2_req_hold", 32'(mem_req_w), 32'd1);
        mem_ack = 1; mem_rdata = 4'h9;
        step(1);
        mem_ack = 0;
        check("t2_out", 32'(out_w), 32'h9);
        check("t2_valid", 32'(out_valid_w), 32'd1);
        check("t2_req_drop", 32'(mem_req_w), 32'd0);

        // Timeout after MEM_WAIT_MAX enabled cycles
        addr_in = 12'h123; fetch_req = 1;
        step(1);
        fetch_req = 0;
        for (int i = 1; i < MEM_WAIT_MAX; i++) step(1);
        check("t3_busy_before", 32'(busy_w), 32'd1);
        step(1);
        check("t3_timeout", 32'(timeout_err_w), 32'd1);
        check("t3_valid", 32'(out_valid_w), 32'd1);
        check("t3_out_hold", 32'(out_w), 32'h9);
        check("t3_req_drop", 32'(mem_req_w), 32'd0);

        // Enable gating and ignored requests while busy
        addr_in = 12'h111; fetch_req = 1;
        step(1);
        fetch_req = 0;
        step(1); step(1);
        for (int i = 0; i < 5; i++) begin
            fetch_req = ~fetch_req; addr_in = 12'h222;
            step(0);
        end
        fetch_req = 1;
        step(1);
        fetch_req = 0;
        check("t4_addr_kept", 32'(mem_addr_w), 32'h111);
        n = 3;
        while (!timeout_err_w && n < 20) begin
            step(1);
            n++;
        end
        check("t4_wait_cycles", 32'(n), 32'(MEM_WAIT_MAX));

        // Reset in the middle of a memory wait; a late ack must be ignored
        addr_in = 12'h0F0; fetch_req = 1;
        step(1);
        fetch_req = 0;
        step(1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t5_req_async", 32'(mem_req_w), 32'd0);
        check("t5_busy", 32'(busy_w), 32'd0);
        mem_ack = 1; mem_rdata = 4'h7;
        step(1);
        reset_n = 1'b1;
        step(1); step(1);
        check("t5_no_valid", 32'(out_valid_w), 32'd0);
        check("t5_out_zero", 32'(out_w), 32'd0);
        mem_ack = 0;

        // Forwarding and out-of-range selector
        src_arr[3] = 4'h1;
        wb_en = 1; wb_sel = 5'd3; wb_data = 4'hE; sel = 5'd3; is_mem = 0; fetch_req = 1;
        step(1);
`ifdef OPERAND_FETCH_WB_FWD_EN
        check("t6_fwd", 32'(out_w), 32'hE);
`else
        check("t6_fwd", 32'(out_w), 32'h1);
`endif
        wb_en = 0; sel = 5'd30;
        step(1);
        fetch_req = 0;
        check("t6_bad_sel", 32'(bad_sel_w), 32'd1);
        check("t6_bad_valid", 32'(out_valid_w), 32'd1);
`ifdef OPERAND_FETCH_WB_FWD_EN
        check("t6_bad_hold", 32'(out_w), 32'hE);
`else
        check("t6_bad_hold", 32'(out_w), 32'h1);
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NUM_SRC; k++) src_arr[k] = DATA_W'($urandom);
            fetch_req = ($urandom_range(0, 1) == 1);
            is_mem    = ($urandom_range(0, 1) == 1);
            sel       = SEL_W'($urandom_range(0, 31));
            addr_in   = ADDR_W'($urandom);
            mem_ack   = ($urandom_range(0, 9) < 3);
            mem_rdata = DATA_W'($urandom);
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_sel    = ($urandom_range(0, 1) == 1) ? sel : SEL_W'($urandom_range(0, 31));
            wb_data   = DATA_W'($urandom);
            if ($urandom_range(0, 499) == 0) reset_pulse();
            else step($urandom_range(0, 3) != 0);
        end

        fetch_req = 0; mem_ack = 0;
        step(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
